// File: rtl/plic_pkg.sv
// Shared constants and types for the platform interrupt arbiter.
package plic_pkg;
  localparam int NSRC_MAX   = 31;
  localparam int ID_W       = 5;
  localparam int PRIO_W_DEF = 3;

  localparam logic [7:0] ADDR_PRIO_BASE = 8'h01;
  localparam logic [7:0] ADDR_ENABLE    = 8'h40;
  localparam logic [7:0] ADDR_THRESH    = 8'h41;
  localparam logic [7:0] ADDR_PENDING   = 8'h42;
  localparam logic [7:0] ADDR_INSERV    = 8'h43;

  typedef logic [PRIO_W_DEF-1:0] prio_t;
endpackage

// File: rtl/plic_arbiter_if.sv
// Core-side bus of the interrupt arbiter: config register port and claim/complete.
// Handshake: claim_req and complete_req are single-cycle pulses with no ready;
// every claim_req is answered by exactly one claim_valid pulse on the next
// cycle, with claim_id valid while claim_valid is high (held until the next
// claim). cfg_rdata is a combinational function of cfg_addr.
interface plic_arbiter_if;
  import plic_pkg::*;

  logic              cfg_we;
  logic [7:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;
  logic              claim_req;
  logic              claim_valid;
  logic [ID_W-1:0]   claim_id;
  logic              complete_req;
  logic [ID_W-1:0]   complete_id;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
    input  cfg_rdata, claim_valid, claim_id
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
    output cfg_rdata, claim_valid, claim_id
  );
endinterface

// File: rtl/plic_gateway.sv
// Per-source gateway: level line to pending, claim moves pending to in-service.
module plic_gateway (
  input  logic clk,
  input  logic resetn,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;

  // A source re-pends only once it is neither pending nor in service; a claim
  // in the same cycle as a complete of this source leaves it in service.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (claim) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else begin
      if (irq && !pending_q && !in_service_q) pending_d = 1'b1;
      if (complete) in_service_d = 1'b0;
    end
  end

  // Gateway state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending    = pending_q;
  assign in_service = in_service_q;
endmodule

// File: rtl/plic_arbiter.sv
// Interrupt arbiter: register file, highest-priority selection and claim logic.
module plic_arbiter
  import plic_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NSRC-1:0] src_irq,
  output logic            PLIC_notif,
  plic_arbiter_if.slave   bus
);
  logic [PRIO_W-1:0] prio_q [NSRC];
  logic [PRIO_W-1:0] prio_d [NSRC];
  logic [NSRC-1:0]   enable_q, enable_d;
  logic [PRIO_W-1:0] thresh_q, thresh_d;
  logic [NSRC-1:0]   pending, in_service, eligible, claim_win, complete_hit;
  logic [ID_W-1:0]   sel_id;
  logic [PRIO_W-1:0] sel_prio;
  logic              claim_valid_q, claim_valid_d;
  logic [ID_W-1:0]   claim_id_q, claim_id_d;
  logic              notif_q, notif_d;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  // Register-port writes to priority, enable and threshold.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      prio_d[i] = prio_q[i];
      if (bus.cfg_we && bus.cfg_addr == ADDR_PRIO_BASE + 8'(i))
        prio_d[i] = bus.cfg_wdata[PRIO_W-1:0];
    end
    enable_d = enable_q;
    thresh_d = thresh_q;
    if (bus.cfg_we && bus.cfg_addr == ADDR_ENABLE) enable_d = bus.cfg_wdata[NSRC-1:0];
    if (bus.cfg_we && bus.cfg_addr == ADDR_THRESH) thresh_d = bus.cfg_wdata[PRIO_W-1:0];
  end

  // Eligibility and selection; strict '>' keeps the lowest ID on ties.
  always_comb begin
    sel_id   = '0;
    sel_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = pending[i] && enable_q[i] && (prio_q[i] > thresh_q);
      if (eligible[i] && (sel_id == '0 || prio_q[i] > sel_prio)) begin
        sel_id   = ID_W'(i + 1);
        sel_prio = prio_q[i];
      end
    end
  end

  // Claim winner and completion decode; out-of-range IDs match no source.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      claim_win[i]    = bus.claim_req && (sel_id == ID_W'(i + 1));
      complete_hit[i] = bus.complete_req && (bus.complete_id == ID_W'(i + 1));
    end
    claim_valid_d = bus.claim_req;
    claim_id_d    = bus.claim_req ? sel_id : claim_id_q;
    notif_d       = |eligible;
  end

  // Configuration and response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
      enable_q      <= '0;
      thresh_q      <= '0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
      notif_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) prio_q[i] <= prio_d[i];
      enable_q      <= enable_d;
      thresh_q      <= thresh_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
      notif_q       <= notif_d;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_gw
    plic_gateway u_gw (
      .clk        (clk),
      .resetn     (resetn),
      .irq        (src_irq[g]),
      .claim      (claim_win[g]),
      .complete   (complete_hit[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // Combinational register read-back.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSRC; i++)
      if (bus.cfg_addr == ADDR_PRIO_BASE + 8'(i)) rdata[PRIO_W-1:0] = prio_q[i];
    case (bus.cfg_addr)
      ADDR_ENABLE:  rdata[NSRC-1:0]   = enable_q;
      ADDR_THRESH:  rdata[PRIO_W-1:0] = thresh_q;
      ADDR_PENDING: rdata[NSRC-1:0]   = pending;
      ADDR_INSERV:  rdata[NSRC-1:0]   = in_service;
      default: ;
    endcase
  end

  assign bus.cfg_rdata   = rdata;
  assign bus.claim_valid = claim_valid_q;
  assign bus.claim_id    = claim_id_q;
  assign PLIC_notif      = notif_q;
endmodule
